// File: rtl/rr_arbiter32.sv
// ============================================================================
// Module   : rr_arbiter32
// Brief    : 32-way round-robin arbiter; holds each grant until done.
//            Optional grant-hold timeout enabled by macro ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter32 #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] req,
    input  logic        done,
    output logic [4:0]  sel,
    output logic [31:0] gnt,
    output logic        valid,
    output logic        timeout
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_sel;
    logic [4:0]  w_sel_nxt;
    logic [4:0]  r_ptr;
    logic [4:0]  w_ptr_nxt;
    logic        w_release;
    logic        w_force;
    logic [31:0] w_cand;
    logic [4:0]  w_start;
    logic [4:0]  w_win;
    logic [4:0]  w_idx;
    logic        w_found;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
        $error("rr_arbiter32: TIMEOUT must be within 2..255");
    end

    assign w_release = (r_state == GRANT) && (done || w_force);
    // On release the search restarts after the holder, whose own request is masked out.
    assign w_start   = w_release ? (r_sel + 5'd1) : r_ptr;
    assign w_cand    = (r_state == GRANT) ? (req & ~(32'd1 << r_sel)) : req;

    // Descending scan so the last hit is the first requester in search order.
    always_comb begin
        w_found = 1'b0;
        w_win   = w_start;
        w_idx   = w_start;
        for (int i = 31; i >= 0; i--) begin
            w_idx = w_start + 5'(i);
            if (w_cand[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = GRANT;
                    w_sel_nxt   = w_win;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_ptr_nxt = r_sel + 5'd1;
                    if (w_found) begin
                        w_sel_nxt = w_win;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_sel   <= 5'd0;
            r_ptr   <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_hold;
    logic       r_timeout;

    // A simultaneous done wins: that edge is an ordinary release, not a timeout.
    assign w_force = (r_state == GRANT) && !done && (r_hold == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold    <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_force;
            r_hold    <= ((r_state == GRANT) && !w_release) ? (r_hold + 8'd1) : 8'd0;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_force = 1'b0;
    assign timeout = 1'b0;
`endif

    assign valid = (r_state == GRANT);
    assign sel   = r_sel;
    assign gnt   = valid ? (32'd1 << r_sel) : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter32.sv
// ============================================================================
// Module   : tb_rr_arbiter32
// Brief    : Vector-table bench for rr_arbiter32 with an expected-output queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rr_arbiter32;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] req;
    logic        done;
    logic [4:0]  sel;
    logic [31:0] gnt;
    logic        valid;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          id;
        logic [31:0] req;
        logic        done;
        logic        ev;
        logic [4:0]  es;
        logic        et;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    rr_arbiter32 #(.TIMEOUT(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .sel     (sel),
        .gnt     (gnt),
        .valid   (valid),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end, got timeout-expired, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(string nm, int id, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h want %h", nm, id, act, exp);
        end
    endtask

    function automatic void add(logic [31:0] r, logic d, logic v, logic [4:0] s, logic t);
        vec_t e;
        e.id = tbl.size(); e.req = r; e.done = d; e.ev = v; e.es = s; e.et = t;
        tbl.push_back(e);
    endfunction

    task automatic score();
        vec_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("valid", e.id, 32'(valid), 32'(e.ev));
            check("sel", e.id, 32'(sel), 32'(e.es));
            check("gnt", e.id, gnt, e.ev ? (32'd1 << e.es) : 32'd0);
            check("timeout", e.id, 32'(timeout), 32'(e.et));
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = 32'd0;
        done  = 1'b0;
        #1;
        check("rst_valid", 0, 32'(valid), 32'd0);
        check("rst_gnt", 0, gnt, 32'd0);
        check("rst_sel", 0, 32'(sel), 32'd0);
        check("rst_timeout", 0, 32'(timeout), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Idle with no requests; done must be ignored while idle.
        for (int i = 0; i < 5; i++) add(32'd0, (i == 2), 1'b0, 5'd0, 1'b0);
        // Single requester, 10-cycle hold (holder drops req midway), then release.
        add(32'h1, 1'b0, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 9; i++) add((i < 4) ? 32'h1 : 32'h0, 1'b0, 1'b1, 5'd0, 1'b0);
        add(32'h0, 1'b1, 1'b0, 5'd0, 1'b0);                 // ptr -> 1
        // Wrap-around between 31 and 0, no bubble; sel holds 31 in idle.
        add(32'h8000_0001, 1'b1, 1'b1, 5'd31, 1'b0);
        add(32'h8000_0001, 1'b1, 1'b1, 5'd0, 1'b0);
        add(32'h8000_0001, 1'b1, 1'b1, 5'd31, 1'b0);
        add(32'h0, 1'b1, 1'b0, 5'd31, 1'b0);                // ptr -> 0
        add(32'h0, 1'b0, 1'b0, 5'd31, 1'b0);
        // Full rotation with every requester active.
        for (int i = 0; i <= 32; i++) add(32'hFFFF_FFFF, 1'b1, 1'b1, 5'(i), 1'b0);
        add(32'h0, 1'b1, 1'b0, 5'd0, 1'b0);                 // ptr -> 1
        // Holder's own request excluded from the search at its release.
        add(32'h4, 1'b0, 1'b1, 5'd2, 1'b0);
        add(32'h4, 1'b1, 1'b0, 5'd2, 1'b0);                 // ptr -> 3
        add(32'h4, 1'b0, 1'b1, 5'd2, 1'b0);
        add(32'h0, 1'b1, 1'b0, 5'd2, 1'b0);                 // ptr -> 3
        // Pointer priority: from ptr 3 bit 3 beats bit 0, then bit 0 follows.
        add(32'h9, 1'b0, 1'b1, 5'd3, 1'b0);
        add(32'h9, 1'b1, 1'b1, 5'd0, 1'b0);
        add(32'h0, 1'b1, 1'b0, 5'd0, 1'b0);                 // ptr -> 1
`ifdef ARB_TIMEOUT_EN
        // Forced release after 16 cycles, then done on the limit cycle.
        for (int i = 0; i < 16; i++) add(32'h60, 1'b0, 1'b1, 5'd5, 1'b0);
        add(32'h60, 1'b0, 1'b1, 5'd6, 1'b1);
        for (int i = 0; i < 15; i++) add(32'h60, 1'b0, 1'b1, 5'd6, 1'b0);
        add(32'h60, 1'b1, 1'b1, 5'd5, 1'b0);
        add(32'h0, 1'b1, 1'b0, 5'd5, 1'b0);
`else
        // Without the timeout a grant is held indefinitely.
        add(32'h40, 1'b0, 1'b1, 5'd6, 1'b0);
        for (int i = 0; i < 24; i++) add(32'h40, 1'b0, 1'b1, 5'd6, 1'b0);
        add(32'h0, 1'b1, 1'b0, 5'd6, 1'b0);
`endif

        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            score();
            req  = tbl[k].req;
            done = tbl[k].done;
            sb.push_back(tbl[k]);
        end
        @(negedge clk);
        score();
        req  = 32'h200;
        done = 1'b0;

        // Asynchronous reset in the middle of a grant to requester 9.
        @(posedge clk);
        #1;
        check("g9_valid", 100, 32'(valid), 32'd1);
        check("g9_sel", 100, 32'(sel), 32'd9);
        check("g9_gnt", 100, gnt, 32'h200);
        #1;
        reset = 1'b1;
        #1;
        check("arst_valid", 101, 32'(valid), 32'd0);
        check("arst_gnt", 101, gnt, 32'd0);
        check("arst_sel", 101, 32'(sel), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        req   = 32'h201;
        @(posedge clk);
        #1;
        check("post_valid", 102, 32'(valid), 32'd1);
        check("post_sel", 102, 32'(sel), 32'd0);
        check("post_gnt", 102, gnt, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
